// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer
//   Turns one SD command request (6-bit index + 32-bit argument) into a 6-byte
//   SPI command frame, feeds it to the byte-level SPI engine one transaction at
//   a time, then polls with 0xFF bytes until an R1 byte (MSB = 0) comes back or
//   POLL_MAX polls have been spent.
//   Optional feature macro: SDCMD_CRC7_EN
//     defined   -> CRC7 of bytes 0..4 is computed serially during their LOAD
//                  cycles and sent as {crc7,1'b1} in byte 5.
//     undefined -> byte 5 comes from a fixed table (CMD0 -> 0x95, CMD8 -> 0x87,
//                  anything else -> 0x01); no CRC logic is built.
module sd_cmd_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned POLL_MAX   = 8,
  parameter logic [2:0]  CLKDIV_RST = 3'b100
) (
  input  logic                      sdcmd_clk_i,
  input  logic                      sdcmd_rst_ni,
  input  logic                      cmd_start_i,
  input  logic [5:0]                cmd_index_i,
  input  logic [31:0]               cmd_arg_i,
  input  logic [2:0]                cfg_clkdiv_i,
  output logic                      cmd_busy_o,
  output logic                      cmd_done_o,
  output logic [7:0]                cmd_resp_o,
  output logic                      cmd_timeout_o,
  output logic [DATA_WIDTH-1:0]     spi_data_o,
  output logic [5:0]                spi_statusreg_o,
  input  logic                      spi_doneflag_i,
  input  logic [2*DATA_WIDTH-1:0]   spi_data_i
);

  localparam int unsigned    PCW          = $clog2(POLL_MAX + 1);
  localparam logic [PCW-1:0] POLL_LAST_M1 = PCW'(POLL_MAX - 1);
  // byte_cnt value that marks the polling phase (all 6 frame bytes sent)
  localparam logic [2:0]     FRAME_LEN    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_POLL = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [5:0]              idx_q, idx_d;
  logic [31:0]             arg_q, arg_d;
  logic [2:0]              clkdiv_q, clkdiv_d;
  logic [2:0]              byte_cnt_q, byte_cnt_d;
  logic [PCW-1:0]          poll_cnt_q, poll_cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [7:0]              resp_q, resp_d;
  logic                    timeout_q, timeout_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    op_q, op_d;
  logic                    flag_prev_q;

  logic [7:0]              frame_byte;
  logic [7:0]              byte5;
  logic [7:0]              rx_hi;
  logic [7:0]              rx_lo;
  logic                    flag_rise;

`ifdef SDCMD_CRC7_EN
  logic [6:0]              crc_q, crc_d;

  // One byte of CRC7 (x^7 + x^3 + 1), MSB first.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] din);
    logic [6:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = din[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  assign byte5 = {crc_q, 1'b1};
`else
  assign byte5 = (idx_q == 6'd0) ? 8'h95 :
                 (idx_q == 6'd8) ? 8'h87 : 8'h01;
`endif

  assign rx_hi     = spi_data_i[2*DATA_WIDTH-1 -: 8];
  assign rx_lo     = spi_data_i[7:0];
  assign flag_rise = spi_doneflag_i & ~flag_prev_q;

  // Byte selected by byte_cnt; counts past the frame read back as the 0xFF poll filler.
  always_comb begin
    frame_byte = 8'hFF;
    case (byte_cnt_q)
      3'd0:    frame_byte = {2'b01, idx_q};
      3'd1:    frame_byte = arg_q[31:24];
      3'd2:    frame_byte = arg_q[23:16];
      3'd3:    frame_byte = arg_q[15:8];
      3'd4:    frame_byte = arg_q[7:0];
      3'd5:    frame_byte = byte5;
      default: frame_byte = 8'hFF;
    endcase
  end

  // Next-state and next-register logic for the command sequencer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    arg_d      = arg_q;
    clkdiv_d   = clkdiv_q;
    byte_cnt_d = byte_cnt_q;
    poll_cnt_d = poll_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    resp_d     = resp_q;
    timeout_d  = timeout_q;
    data_d     = data_q;
    op_d       = op_q;
`ifdef SDCMD_CRC7_EN
    crc_d      = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_start_i) begin
          idx_d      = cmd_index_i;
          arg_d      = cmd_arg_i;
          clkdiv_d   = cfg_clkdiv_i;
          byte_cnt_d = 3'd0;
          poll_cnt_d = '0;
          busy_d     = 1'b1;
`ifdef SDCMD_CRC7_EN
          crc_d      = 7'd0;
`endif
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        data_d  = DATA_WIDTH'(frame_byte);
        op_d    = 1'b1;
`ifdef SDCMD_CRC7_EN
        if (byte_cnt_q < 3'd5) begin
          crc_d = crc7_byte(crc_q, frame_byte);
        end
`endif
        state_d = S_REQ;
      end
      S_POLL: begin
        data_d  = DATA_WIDTH'(8'hFF);
        op_d    = 1'b1;
        state_d = S_REQ;
      end
      S_REQ: begin
        // A done flag still high from the previous byte is stale; keep the
        // request up until the engine drops the flag to show it has restarted.
        if (!spi_doneflag_i) begin
          op_d    = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flag_rise) begin
          if (byte_cnt_q != FRAME_LEN) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            state_d    = (byte_cnt_q == 3'd5) ? S_POLL : S_LOAD;
          end else if (!rx_hi[7]) begin
            resp_d    = rx_hi;
            timeout_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else if (!rx_lo[7]) begin
            resp_d    = rx_lo;
            timeout_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else if (poll_cnt_q == POLL_LAST_M1) begin
            poll_cnt_d = poll_cnt_q + PCW'(1);
            resp_d     = 8'hFF;
            timeout_d  = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end else begin
            poll_cnt_d = poll_cnt_q + PCW'(1);
            state_d    = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge sdcmd_clk_i or negedge sdcmd_rst_ni) begin
    if (!sdcmd_rst_ni) begin
      state_q     <= S_IDLE;
      idx_q       <= 6'd0;
      arg_q       <= 32'd0;
      clkdiv_q    <= CLKDIV_RST;
      byte_cnt_q  <= 3'd0;
      poll_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      resp_q      <= 8'h00;
      timeout_q   <= 1'b0;
      data_q      <= {DATA_WIDTH{1'b1}};
      op_q        <= 1'b0;
      flag_prev_q <= 1'b0;
`ifdef SDCMD_CRC7_EN
      crc_q       <= 7'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      arg_q       <= arg_d;
      clkdiv_q    <= clkdiv_d;
      byte_cnt_q  <= byte_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      resp_q      <= resp_d;
      timeout_q   <= timeout_d;
      data_q      <= data_d;
      op_q        <= op_d;
      flag_prev_q <= spi_doneflag_i;
`ifdef SDCMD_CRC7_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign cmd_busy_o      = busy_q;
  assign cmd_done_o      = done_q;
  assign cmd_resp_o      = resp_q;
  assign cmd_timeout_o   = timeout_q;
  assign spi_data_o      = data_q;
  assign spi_statusreg_o = {clkdiv_q, 1'b1, 1'b1, op_q};

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer
//   Drives sd_cmd_sequencer against a behavioural SPI engine with random
//   latency and random frame-phase read data. Expected frames and R1 results
//   come from a plain model (polynomial long division for CRC7, a linear scan
//   over the scripted poll words for R1). Honours SDCMD_CRC7_EN.
`timescale 1ns/1ps
module tb_sd_cmd_sequencer;
  localparam int         POLL_MAX   = 8;
  localparam logic [2:0] CLKDIV_RST = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [5:0]  cmd_index = 6'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic [2:0]  cfg_clkdiv = 3'd0;
  logic        busy, done, timeout;
  logic [7:0]  resp, spi_tx;
  logic [5:0]  status;
  logic        spi_doneflag;
  logic [15:0] spi_rx;

  always #5 clk = ~clk;

  sd_cmd_sequencer #(.DATA_WIDTH(8), .POLL_MAX(POLL_MAX), .CLKDIV_RST(CLKDIV_RST)) dut (
    .sdcmd_clk_i     (clk),
    .sdcmd_rst_ni    (rst_n),
    .cmd_start_i     (cmd_start),
    .cmd_index_i     (cmd_index),
    .cmd_arg_i       (cmd_arg),
    .cfg_clkdiv_i    (cfg_clkdiv),
    .cmd_busy_o      (busy),
    .cmd_done_o      (done),
    .cmd_resp_o      (resp),
    .cmd_timeout_o   (timeout),
    .spi_data_o      (spi_tx),
    .spi_statusreg_o (status),
    .spi_doneflag_i  (spi_doneflag),
    .spi_data_i      (spi_rx)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // CRC7 by long division of the 40-bit message (times x^7) by x^7+x^3+1.
  function automatic logic [6:0] crc_model(input logic [5:0] idx, input logic [31:0] arg);
    logic [46:0] m;
    m = {2'b01, idx, arg, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
    end
    return m[6:0];
  endfunction

  function automatic logic [7:0] table_byte5(input logic [5:0] idx);
    if (idx == 6'd0) return 8'h95;
    if (idx == 6'd8) return 8'h87;
    return 8'h01;
  endfunction

  logic [15:0] poll_words [POLL_MAX];
  logic [7:0]  tx_log [$];
  logic [7:0]  exp_bytes [$];
  logic [7:0]  exp_resp = 8'h00;
  logic        exp_timeout = 1'b0;
  logic [2:0]  exp_clkdiv = CLKDIV_RST;
  logic        flag_init = 1'b1;
  int          done_cnt = 0;

  // First R1-looking byte in the scripted poll words, or a timeout.
  task automatic model_outcome(output int np, output logic [7:0] r, output logic t);
    np = POLL_MAX; r = 8'hFF; t = 1'b1;
    for (int i = 0; i < POLL_MAX; i++) begin
      if (!poll_words[i][15]) begin
        np = i + 1; r = poll_words[i][15:8]; t = 1'b0; break;
      end
      if (!poll_words[i][7]) begin
        np = i + 1; r = poll_words[i][7:0]; t = 1'b0; break;
      end
    end
  endtask

  task automatic set_polls(input logic [15:0] first);
    for (int i = 0; i < POLL_MAX; i++) poll_words[i] = 16'hFFFF;
    poll_words[0] = first;
  endtask

  // ---------------- engine model ----------------
  logic        eng_busy;
  logic [1:0]  eng_cnt;
  logic [15:0] eng_word;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_busy     <= 1'b0;
      eng_cnt      <= 2'd0;
      eng_word     <= 16'hFFFF;
      spi_doneflag <= flag_init;
      spi_rx       <= 16'hFFFF;
    end else if (eng_busy) begin
      if (eng_cnt == 2'd0) begin
        eng_busy     <= 1'b0;
        spi_doneflag <= 1'b1;
        spi_rx       <= eng_word;
      end else begin
        eng_cnt <= eng_cnt - 2'd1;
      end
    end else if (status[0]) begin
      eng_busy     <= 1'b1;
      spi_doneflag <= 1'b0;
      eng_cnt      <= 2'($urandom_range(0, 3));
      if (tx_log.size() < 6)
        eng_word <= 16'($urandom);
      else if (tx_log.size() < 6 + POLL_MAX)
        eng_word <= poll_words[tx_log.size() - 6];
      else
        eng_word <= 16'hFFFF;
      tx_log.push_back(spi_tx);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    logic [7:0] last_resp;
    logic       prev_done;
    int         first_bad;
    last_resp = 8'h00;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_resp = 8'h00;
        prev_done = 1'b0;
      end else begin
        chk("status_fixed_bits", 32'(status[2:1]), 32'd3);
        chk("status_clkdiv", 32'(status[5:3]), 32'(exp_clkdiv));
        if (status[0]) chk("op_implies_busy", 32'(busy), 32'd1);
        if (done) begin
          chk("done_single_cycle", 32'(prev_done), 32'd0);
          chk("busy_low_at_done", 32'(busy), 32'd0);
          chk("resp_at_done", 32'(resp), 32'(exp_resp));
          chk("timeout_at_done", 32'(timeout), 32'(exp_timeout));
          chk("txn_count", 32'(tx_log.size()), 32'(exp_bytes.size()));
          first_bad = -1;
          for (int i = 0; i < exp_bytes.size() && i < tx_log.size(); i++) begin
            if (first_bad < 0 && tx_log[i] !== exp_bytes[i]) first_bad = i;
          end
          chk("tx_bytes_first_bad_index", 32'(first_bad), 32'hFFFF_FFFF);
          last_resp = resp;
          done_cnt++;
        end else begin
          chk("resp_held", 32'(resp), 32'(last_resp));
        end
        prev_done = done;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] cdiv);
    @(negedge clk);
    tx_log.delete();
    cmd_index  = idx;
    cmd_arg    = arg;
    cfg_clkdiv = cdiv;
    cmd_start  = 1'b1;
    @(posedge clk);
    exp_clkdiv = cdiv;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("op_low_1_cycle", 32'(status[0]), 32'd0);
    // inputs after accept must not leak into the running command
    cfg_clkdiv = 3'($urandom);
    cmd_index  = 6'($urandom);
    cmd_arg    = $urandom;
    @(negedge clk);
    chk("op_high_2_cycles", 32'(status[0]), 32'd1);
    chk("first_frame_byte", 32'(spi_tx), 32'({2'b01, idx}));
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] cdiv,
                         input bit spam);
    int         np;
    logic [7:0] r;
    logic       t;
    bit         got;
    model_outcome(np, r, t);
    exp_bytes.delete();
    exp_bytes.push_back({2'b01, idx});
    exp_bytes.push_back(arg[31:24]);
    exp_bytes.push_back(arg[23:16]);
    exp_bytes.push_back(arg[15:8]);
    exp_bytes.push_back(arg[7:0]);
`ifdef SDCMD_CRC7_EN
    exp_bytes.push_back({crc_model(idx, arg), 1'b1});
`else
    exp_bytes.push_back(table_byte5(idx));
`endif
    for (int i = 0; i < np; i++) exp_bytes.push_back(8'hFF);
    exp_resp    = r;
    exp_timeout = t;
    start_cmd(idx, arg, cdiv);
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (spam) cmd_start = 1'($urandom);
      @(negedge clk);
    end
    cmd_start = 1'b0;
    chk("done_within_bound", 32'(got), 32'd1);
    $display("cmd idx=%0d arg=%08h resp=%02h timeout=%0d txns=%0d", idx, arg, resp, timeout,
             tx_log.size());
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int         d0;
    logic [5:0] ridx;
    bit         reached;
    set_polls(16'hFFFF);

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_spi_data", 32'(spi_tx), 32'hFF);
    chk("rst_statusreg", 32'(status), 32'h26);
    #2 rst_n = 1'b1;

    // pin the CRC model to known SD command checksums
    chk("model_crc_cmd0", 32'(crc_model(6'd0, 32'd0)), 32'h4A);
    chk("model_crc_cmd8", 32'(crc_model(6'd8, 32'h1AA)), 32'h43);
    chk("model_crc_cmd17", 32'(crc_model(6'd17, 32'd0)), 32'h2A);

    // CMD0, R1 = 0x01 in the low byte of the first poll
    set_polls(16'hFF01);
    run_cmd(6'd0, 32'd0, 3'd2, 1'b0);
    chk("cmd0_resp", 32'(resp), 32'h01);
    chk("cmd0_timeout", 32'(timeout), 32'd0);
    chk("cmd0_txns", 32'(tx_log.size()), 32'd7);
    if (tx_log.size() >= 6) begin
      chk("cmd0_byte0", 32'(tx_log[0]), 32'h40);
      chk("cmd0_byte4", 32'(tx_log[4]), 32'h00);
      chk("cmd0_byte5", 32'(tx_log[5]), 32'h95);
    end

    // CMD8 0x1AA and CMD17 0
    set_polls(16'h01FF);
    run_cmd(6'd8, 32'h0000_01AA, 3'd5, 1'b0);
    if (tx_log.size() >= 6) begin
      chk("cmd8_byte0", 32'(tx_log[0]), 32'h48);
      chk("cmd8_byte4", 32'(tx_log[4]), 32'hAA);
      chk("cmd8_byte5", 32'(tx_log[5]), 32'h87);
    end
    set_polls(16'hFF00);
    run_cmd(6'd17, 32'd0, 3'd1, 1'b0);
    if (tx_log.size() >= 6) begin
`ifdef SDCMD_CRC7_EN
      chk("cmd17_byte5", 32'(tx_log[5]), 32'h55);
`else
      chk("cmd17_byte5", 32'(tx_log[5]), 32'h01);
`endif
    end

    // no R1 at all -> timeout after POLL_MAX polls
    set_polls(16'hFFFF);
    run_cmd(6'd55, 32'hDEAD_BEEF, 3'd3, 1'b0);
    chk("timeout_flag", 32'(timeout), 32'd1);
    chk("timeout_resp", 32'(resp), 32'hFF);
    chk("timeout_txns", 32'(tx_log.size()), 32'(6 + POLL_MAX));

    // R1 in the low byte, then in the high byte
    set_polls(16'hFF00);
    run_cmd(6'd1, 32'h1234_5678, 3'd4, 1'b0);
    chk("lowbyte_resp", 32'(resp), 32'h00);
    chk("lowbyte_txns", 32'(tx_log.size()), 32'd7);
    set_polls(16'h05FF);
    run_cmd(6'd2, 32'h8000_0001, 3'd6, 1'b0);
    chk("highbyte_resp", 32'(resp), 32'h05);

    // randomized commands
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < POLL_MAX; i++) begin
        case ($urandom_range(0, 5))
          0:       poll_words[i] = {1'b0, 7'($urandom), 8'($urandom)};
          1:       poll_words[i] = {1'b1, 7'($urandom), 1'b0, 7'($urandom)};
          default: poll_words[i] = {1'b1, 7'($urandom), 1'b1, 7'($urandom)};
        endcase
      end
      ridx = ($urandom_range(0, 3) == 0) ? 6'd8 : 6'($urandom);
      run_cmd(ridx, $urandom, 3'($urandom), (n % 4) == 0);
    end

    // start pulses while busy are ignored
    d0 = done_cnt;
    set_polls(16'hFFFF);
    poll_words[2] = 16'h3CFF;
    run_cmd(6'd41, 32'h4000_0000, 3'd7, 1'b1);
    chk("spam_resp", 32'(resp), 32'h3C);
    repeat (12) @(negedge clk);
    chk("spam_idle_busy", 32'(busy), 32'd0);
    chk("spam_one_done", 32'(done_cnt - d0), 32'd1);
    chk("spam_no_extra_frame", 32'(tx_log.size()), 32'(exp_bytes.size()));

    // reset while byte 3 is in flight
    set_polls(16'hFFFF);
    start_cmd(6'd17, 32'hA5A5_5A5A, 3'd2);
    reached = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (tx_log.size() >= 4) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("byte3_reached", 32'(reached), 32'd1);
    if (reached) chk("byte3_value", 32'(tx_log[3]), 32'h5A);
    chk("busy_before_reset", 32'(busy), 32'd1);
    #2;
    flag_init  = 1'b0;
    exp_clkdiv = CLKDIV_RST;
    rst_n      = 1'b0;
    #1;
    chk("midrst_op", 32'(status[0]), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_statusreg", 32'(status), 32'h26);
    chk("midrst_spi_data", 32'(spi_tx), 32'hFF);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // CMD0 after the mid-command reset
    set_polls(16'hFF01);
    run_cmd(6'd0, 32'd0, 3'd0, 1'b0);
    chk("post_rst_resp", 32'(resp), 32'h01);
    chk("post_rst_timeout", 32'(timeout), 32'd0);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
